// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and legal parameter ranges.
// Used by the packet transmitter and intended for the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int unsigned PKT_BYTES_MIN    = 1;
  localparam int unsigned DATA_BITS_MIN    = 5;
  localparam int unsigned DATA_BITS_MAX    = 9;
  localparam int unsigned STOP_BITS_MIN    = 1;
  localparam int unsigned STOP_BITS_MAX    = 2;
  localparam int unsigned CLKS_PER_BIT_MIN = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts modulo CLKS_PER_BIT, restarts on clear_i.
// bit_end_o marks the last clock of a bit period, pre_end_o the clock before it.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic pre_end_o,
  output logic bit_end_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_baud_tick: CLKS_PER_BIT must be at least 2");
  end

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_end_o = (cnt_q == LAST);
  assign pre_end_o = (cnt_q == PRE);

endmodule

// File: rtl/uart_tx_packet.sv
// Packet UART transmitter: sends PKT_BYTES frames back to back after a valid/ready accept.
// Optional parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_packet
  import uart_pkg::*;
#(
  parameter int unsigned PKT_BYTES    = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned MSB_BYTE_1ST = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [PKT_BYTES*DATA_BITS-1:0] pkt_data,
  output logic                           txd,
  output logic                           busy,
  output logic [$clog2(PKT_BYTES):0]     byte_idx,
  output logic                           byte_done,
  output logic                           pkt_done
);

  localparam int unsigned W  = PKT_BYTES * DATA_BITS;
  localparam int unsigned IW = $clog2(PKT_BYTES) + 1;
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_BYTES);
  localparam logic          LAST_STOP = (STOP_BITS == 2);

  if (PKT_BYTES < PKT_BYTES_MIN) begin : g_bad_pkt_bytes
    $error("uart_tx_packet: PKT_BYTES must be at least 1");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_tx_packet: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_tx_packet: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
    $error("uart_tx_packet: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_tx_packet: PARITY_ODD must be 0 or 1");
  end

  uart_state_e         state_q;
  logic                txd_q;
  logic                ready_q;
  logic                busy_q;
  logic [IW-1:0]       byte_idx_q;
  logic                byte_done_q;
  logic                pkt_done_q;
  logic [BW-1:0]       bit_cnt_q;
  logic                stop_cnt_q;
  logic [DATA_BITS-1:0] sh_q;
  logic [W-1:0]        buf_q;
`ifdef UART_TX_PARITY_EN
  logic                par_q;
`endif

  logic pre_end;
  logic bit_end;
  logic last_stop;
  logic [W-1:0] pkt_ord;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (state_q == IDLE),
    .pre_end_o(pre_end),
    .bit_end_o(bit_end)
  );

  // Reorder once at accept so byte 0 always sits in the bottom slice of buf_q.
  always_comb begin
    pkt_ord = '0;
    for (int unsigned i = 0; i < PKT_BYTES; i++) begin
      if (MSB_BYTE_1ST != 0) begin
        pkt_ord[i*DATA_BITS +: DATA_BITS] = pkt_data[(PKT_BYTES-1-i)*DATA_BITS +: DATA_BITS];
      end else begin
        pkt_ord[i*DATA_BITS +: DATA_BITS] = pkt_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign last_stop = (stop_cnt_q == LAST_STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      txd_q       <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      byte_idx_q  <= '0;
      byte_done_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      sh_q        <= '0;
      buf_q       <= '0;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      byte_done_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pkt_valid) begin
            state_q <= START;
            txd_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            sh_q    <= pkt_ord[DATA_BITS-1:0];
            buf_q   <= pkt_ord >> DATA_BITS;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^pkt_ord[DATA_BITS-1:0];
`endif
          end
        end
        START: begin
          if (bit_end) begin
            state_q   <= DATA;
            txd_q     <= sh_q[0];
            sh_q      <= sh_q >> 1;
            bit_cnt_q <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q    <= PARITY;
              txd_q      <= par_q ^ (PARITY_ODD != 0);
`else
              state_q    <= STOP;
              txd_q      <= 1'b1;
              stop_cnt_q <= 1'b0;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
              txd_q     <= sh_q[0];
              sh_q      <= sh_q >> 1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q    <= STOP;
            txd_q      <= 1'b1;
            stop_cnt_q <= 1'b0;
          end
        end
        STOP: begin
          // byte_done is registered, so it is raised one clock ahead of the bit end.
          if (last_stop && pre_end) begin
            byte_done_q <= 1'b1;
            byte_idx_q  <= byte_idx_q + IW'(1);
          end
          if (bit_end) begin
            if (!last_stop) begin
              stop_cnt_q <= 1'b1;
            end else if (byte_idx_q == LAST_IDX) begin
              state_q    <= IDLE;
              ready_q    <= 1'b1;
              busy_q     <= 1'b0;
              pkt_done_q <= 1'b1;
              byte_idx_q <= '0;
            end else begin
              state_q <= START;
              txd_q   <= 1'b0;
              sh_q    <= buf_q[DATA_BITS-1:0];
              buf_q   <= buf_q >> DATA_BITS;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^buf_q[DATA_BITS-1:0];
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd       = txd_q;
  assign pkt_ready = ready_q;
  assign busy      = busy_q;
  assign byte_idx  = byte_idx_q;
  assign byte_done = byte_done_q;
  assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_uart_tx_packet.sv
// Bench for uart_tx_packet: frame-level reference model plus directed packets
// on an 8N1 MSB-first instance and a 7-bit, 2-stop, LSB-first instance.
module tb_uart_tx_packet;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int PODD = 0;
  localparam int F = (PAR != 0) ? 44 : 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_valid, a_ready, a_txd, a_busy, a_bd, a_pd;
  logic [15:0] a_data;
  logic [1:0]  a_idx;
  logic b_valid, b_ready, b_txd, b_busy, b_bd, b_pd;
  logic [13:0] b_data;
  logic [1:0]  b_idx;

  uart_tx_packet #(
    .PKT_BYTES(2), .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1),
    .MSB_BYTE_1ST(1), .PARITY_ODD(PODD)
  ) dut_a (
    .clk(clk), .rst(rst), .pkt_valid(a_valid), .pkt_ready(a_ready), .pkt_data(a_data),
    .txd(a_txd), .busy(a_busy), .byte_idx(a_idx), .byte_done(a_bd), .pkt_done(a_pd)
  );

  uart_tx_packet #(
    .PKT_BYTES(2), .DATA_BITS(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2),
    .MSB_BYTE_1ST(0), .PARITY_ODD(PODD)
  ) dut_b (
    .clk(clk), .rst(rst), .pkt_valid(b_valid), .pkt_ready(b_ready), .pkt_data(b_data),
    .txd(b_txd), .busy(b_busy), .byte_idx(b_idx), .byte_done(b_bd), .pkt_done(b_pd)
  );

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-clock outputs, built from the frame rules at accept time.
  typedef struct packed {
    logic       txd;
    logic       ready;
    logic       bd;
    logic       pd;
    logic [1:0] idx;
  } exp_t;

  localparam exp_t IDLE_E = '{txd: 1'b1, ready: 1'b1, bd: 1'b0, pd: 1'b0, idx: 2'd0};

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a = IDLE_E;
  exp_t cur_b = IDLE_E;

  task automatic model_pkt(input int which, input int db, input int sb, input bit msb,
                           input logic [15:0] data);
    exp_t e;
    logic [8:0] byt;
    logic bits[$];
    int sh;
    int n;
    for (int b = 0; b < 2; b++) begin
      sh = msb ? db * (1 - b) : db * b;
      byt = 9'((data >> sh) & ((16'd1 << db) - 16'd1));
      bits.delete();
      bits.push_back(1'b0);
      for (int i = 0; i < db; i++) bits.push_back(byt[i]);
      if (PAR != 0) bits.push_back((^byt) ^ (PODD != 0));
      for (int s = 0; s < sb; s++) bits.push_back(1'b1);
      n = bits.size() * CPB;
      for (int k = 0; k < n; k++) begin
        e.txd   = bits[k / CPB];
        e.ready = 1'b0;
        e.bd    = (k == n - 1);
        e.pd    = 1'b0;
        e.idx   = e.bd ? 2'(b + 1) : 2'(b);
        if (which == 0) qa.push_back(e); else qb.push_back(e);
      end
    end
    e = '{txd: 1'b1, ready: 1'b1, bd: 1'b0, pd: 1'b1, idx: 2'd0};
    if (which == 0) qa.push_back(e); else qb.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (a_valid && cur_a.ready) model_pkt(0, 8, 1, 1'b1, a_data);
      if (b_valid && cur_b.ready) model_pkt(1, 7, 2, 1'b0, {2'b00, b_data});
    end
  end

  always @(negedge clk) begin
    if (qa.size() > 0) cur_a = qa.pop_front(); else cur_a = IDLE_E;
    if (qb.size() > 0) cur_b = qb.pop_front(); else cur_b = IDLE_E;
    if (chk_en) begin
      chk("a.txd", a_txd, cur_a.txd);
      chk("a.ready", a_ready, cur_a.ready);
      chk("a.busy", a_busy, !cur_a.ready);
      chk("a.byte_done", a_bd, cur_a.bd);
      chk("a.pkt_done", a_pd, cur_a.pd);
      chk("a.byte_idx", a_idx, cur_a.idx);
      chk("b.txd", b_txd, cur_b.txd);
      chk("b.ready", b_ready, cur_b.ready);
      chk("b.busy", b_busy, !cur_b.ready);
      chk("b.byte_done", b_bd, cur_b.bd);
      chk("b.pkt_done", b_pd, cur_b.pd);
      chk("b.byte_idx", b_idx, cur_b.idx);
    end
  end

  // Capture log indexed by clocks since the accept edge (cycle 1 = start bit begins).
  logic txd_log [0:255];
  int bd_cyc [0:7];
  int n_bd;
  int pd_cyc;

  task automatic run_capture(input int which, input int ncyc);
    n_bd = 0;
    pd_cyc = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      txd_log[k] = (which == 0) ? a_txd : b_txd;
      if ((which == 0) ? a_bd : b_bd) begin
        if (n_bd < 8) bd_cyc[n_bd] = k;
        n_bd++;
      end
      if (((which == 0) ? a_pd : b_pd) && pd_cyc < 0) pd_cyc = k;
    end
  endtask

  function automatic logic [8:0] dec(input int base, input int db);
    logic [8:0] v;
    v = '0;
    for (int i = 0; i < db; i++) v[i] = txd_log[base + CPB + CPB * i + 1];
    return v;
  endfunction

  task automatic wait_pd(input int which, input int max, input string nm);
    int got;
    got = 0;
    for (int k = 0; k < max && got == 0; k++) begin
      @(negedge clk);
      if ((which == 0) ? a_pd : b_pd) got = 1;
    end
    chk(nm, got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int run;
    int n;
    int ss;
    rst = 1'b1;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;

    // 1: reset held 3 clocks, then idle with pkt_valid low
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t1.rst_txd", a_txd, 1'b1);
    chk("t1.rst_ready", a_ready, 1'b1);
    chk("t1.rst_busy", a_busy, 1'b0);
    chk("t1.rst_pulses", {a_bd, a_pd}, 2'b00);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1.idle_txd", a_txd, 1'b1);
    chk("t1.idle_ready", a_ready, 1'b1);

    // 2: single packet A53C, MSB byte first
    a_data = 16'hA53C; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0; a_data = 16'h0000;
    run_capture(0, 2 * F + 4);
    chk("t2.start_bit", txd_log[1], 1'b0);
    chk("t2.byte0", dec(1, 8), 9'h0A5);
    chk("t2.byte1", dec(1 + F, 8), 9'h03C);
    chk("t2.n_byte_done", n_bd, 2);
    chk("t2.byte_done0_clk", bd_cyc[0], F);
    chk("t2.byte_done1_clk", bd_cyc[1], 2 * F);
    chk("t2.pkt_done_clk", pd_cyc, 2 * F + 1);

    // 3: pkt_valid held across two packets, then a pulse while busy
    @(negedge clk);
    a_data = 16'h0102; a_valid = 1'b1;
    @(posedge clk); #1;
    a_data = 16'hFF00;
    run_capture(0, 2 * F + 2);
    a_valid = 1'b0;
    chk("t3.byte0", dec(1, 8), 9'h001);
    chk("t3.byte1", dec(1 + F, 8), 9'h002);
    run = 0;
    for (int k = 2 * F + 1; k > 0 && txd_log[k] === 1'b1; k--) run++;
    chk("t3.gap_high_clks", run, (PAR != 0) ? ((PODD != 0) ? 5 : 9) : 5);
    chk("t3.second_start", txd_log[2 * F + 2], 1'b0);
    chk("t3.busy_second", a_busy, 1'b1);
    repeat (10) @(negedge clk);
    a_data = 16'h1234; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    wait_pd(0, 2 * F + 10, "t3.second_pkt_done");
    repeat (3) @(negedge clk);
    chk("t3.idle_after", {a_ready, a_txd}, 2'b11);

    // 4: reset at clock 20 of a packet, then a clean packet
    a_data = 16'h5AC3; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4.rst_txd", a_txd, 1'b1);
    chk("t4.rst_ready", a_ready, 1'b1);
    n = 0;
    repeat (2 * F) begin
      @(negedge clk);
      if (a_bd || a_pd) n++;
    end
    chk("t4.no_pulses", n, 0);
    a_data = 16'hC35A; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    run_capture(0, 2 * F + 2);
    chk("t4.byte0", dec(1, 8), 9'h0C3);
    chk("t4.byte1", dec(1 + F, 8), 9'h05A);
    chk("t4.pkt_done_clk", pd_cyc, 2 * F + 1);

`ifdef UART_TX_PARITY_EN
    // 5: parity bit for byte 07
    @(negedge clk);
    a_data = 16'h0700; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    run_capture(0, 2 * F + 2);
    chk("t5.parity_bit", txd_log[38], (PODD != 0) ? 1'b0 : 1'b1);
    chk("t5.frame_clks", bd_cyc[0], 44);
`endif

    // 6: 7 data bits, 2 stop bits, LSB byte first
    @(negedge clk);
    b_data = 14'h0A55; b_valid = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0;
    run_capture(1, 2 * F + 2);
    chk("t6.byte0", dec(1, 7), 9'h055);
    chk("t6.byte1", dec(1 + F, 7), 9'h014);
    chk("t6.byte_done0_clk", bd_cyc[0], F);
    chk("t6.byte_done1_clk", bd_cyc[1], 2 * F);
    chk("t6.pkt_done_clk", pd_cyc, 2 * F + 1);
    ss = 1 + CPB + 7 * CPB + PAR * CPB;
    n = 0;
    for (int k = ss; k < ss + 2 * CPB; k++) if (txd_log[k] === 1'b1) n++;
    chk("t6.stop_high_clks", n, 8);
    chk("t6.next_start", txd_log[ss + 2 * CPB], 1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
